wr_ingress_ctrl: RTL and testbench

WR_INGRESS_CTRL -- requirements
Module: wr_ingress_ctrl

---
 rtl/fifo_pkg.sv | 13 +
 rtl/gray2bin.sv | 14 +
 rtl/wr_ingress_ctrl.sv | 118 +++++++++++
 tb/tb_wr_ingress_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: default geometry and the ingress skid-buffer state encoding.
package fifo_pkg;

  localparam int FIFO_ADDR_SIZE = 8;
  localparam int FIFO_DATA_SIZE = 8;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HOLD1 = 2'd1,
    HOLD2 = 2'd2
  } wr_state_e;

endpackage

// File: rtl/gray2bin.sv
// Combinational Gray-to-binary converter of configurable width.
module gray2bin #(
  parameter int W = 9
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  // Each binary bit is the XOR of all Gray bits at or above it.
  for (genvar i = 0; i < W; i++) begin : g_bit
    assign bin[i] = ^gray[W-1:i];
  end

endmodule

// File: rtl/wr_ingress_ctrl.sv
// Write-side ingress: 2-entry skid buffer feeding the FIFO write port, plus fill-level tracking.
// Optional upstream stall counter enabled by defining WR_INGRESS_STATS_EN.
module wr_ingress_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_SIZE    = FIFO_ADDR_SIZE,
  parameter int DATA_SIZE    = FIFO_DATA_SIZE,
  parameter int AFULL_MARGIN = 4
) (
  input  logic                 wclk,
  input  logic                 wrst_n,
  input  logic                 s_valid,
  input  logic [DATA_SIZE-1:0] s_data,
  output logic                 s_ready,
  output logic                 winc,
  output logic [DATA_SIZE-1:0] wdata,
  input  logic                 wfull,
  input  logic [ADDR_SIZE:0]   wptr,
  input  logic [ADDR_SIZE:0]   wq2_rptr,
  output logic [ADDR_SIZE:0]   wlevel,
  output logic                 walmost_full,
  output logic [15:0]          wstall_cnt
);

  localparam int PW = ADDR_SIZE + 1;
  localparam logic [PW-1:0] AFULL_LEVEL = PW'((2 ** ADDR_SIZE) - AFULL_MARGIN);

  wr_state_e            state_d, state_q;
  logic [DATA_SIZE-1:0] head_d, head_q;
  logic [DATA_SIZE-1:0] skid_d, skid_q;
  logic                 s_ready_d, s_ready_q;
  logic [PW-1:0]        wbin, rbin;
  logic [PW-1:0]        wlevel_d, wlevel_q;
  logic                 afull_d, afull_q;
  logic                 accept, drain;

  gray2bin #(.W(PW)) u_g2b_wptr (.gray(wptr),     .bin(wbin));
  gray2bin #(.W(PW)) u_g2b_rptr (.gray(wq2_rptr), .bin(rbin));

  assign accept  = s_valid & s_ready_q;
  assign drain   = winc;
  assign winc    = (state_q != EMPTY) & ~wfull;
  assign wdata   = head_q;
  assign s_ready = s_ready_q;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: if (accept) begin
        head_d  = s_data;
        state_d = HOLD1;
      end
      HOLD1: begin
        if (accept && drain) begin
          head_d = s_data;
        end else if (accept) begin
          skid_d  = s_data;
          state_d = HOLD2;
        end else if (drain) begin
          state_d = EMPTY;
        end
      end
      // s_ready is low here, so only a drain can happen; the skid word moves up in order.
      HOLD2: if (drain) begin
        head_d  = skid_q;
        state_d = HOLD1;
      end
      default: state_d = EMPTY;
    endcase
    s_ready_d = (state_d != HOLD2);
  end

  // Modular subtraction handles pointer wrap; MSB difference alone yields a full level.
  assign wlevel_d = wbin - rbin;
  assign afull_d  = (wlevel_d >= AFULL_LEVEL);

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q   <= EMPTY;
      head_q    <= '0;
      skid_q    <= '0;
      s_ready_q <= 1'b0;
      wlevel_q  <= '0;
      afull_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      head_q    <= head_d;
      skid_q    <= skid_d;
      s_ready_q <= s_ready_d;
      wlevel_q  <= wlevel_d;
      afull_q   <= afull_d;
    end
  end

  assign wlevel       = wlevel_q;
  assign walmost_full = afull_q;

`ifdef WR_INGRESS_STATS_EN
  logic [15:0] stall_cnt_d, stall_cnt_q;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (s_valid && !s_ready_q && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) stall_cnt_q <= '0;
    else         stall_cnt_q <= stall_cnt_d;
  end

  assign wstall_cnt = stall_cnt_q;
`else
  assign wstall_cnt = '0;
`endif

endmodule

// File: tb/tb_wr_ingress_ctrl.sv
// Scoreboard bench for wr_ingress_ctrl (ADDR_SIZE=4, AFULL_MARGIN=4).
module tb_wr_ingress_ctrl;

  localparam int AW = 4;
  localparam int DW = 8;

`ifdef WR_INGRESS_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          wclk = 1'b0;
  logic          wrst_n = 1'b1;
  logic          s_valid = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_ready;
  logic          winc;
  logic [DW-1:0] wdata;
  logic          wfull = 1'b0;
  logic [AW:0]   wptr = '0;
  logic [AW:0]   wq2_rptr = '0;
  logic [AW:0]   wlevel;
  logic          walmost_full;
  logic [15:0]   wstall_cnt;

  int checks = 0;
  int errors = 0;
  int stall_model = 0;
  bit acc;
  logic [DW-1:0] sb[$];

  wr_ingress_ctrl #(.ADDR_SIZE(AW), .DATA_SIZE(DW), .AFULL_MARGIN(4)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .winc(winc), .wdata(wdata), .wfull(wfull), .wptr(wptr), .wq2_rptr(wq2_rptr),
    .wlevel(wlevel), .walmost_full(walmost_full), .wstall_cnt(wstall_cnt)
  );

  always #5 wclk = ~wclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [AW:0] gray(input logic [AW:0] b);
    return b ^ (b >> 1);
  endfunction

  // One clock: score the pre-edge view at the falling edge, return just after the rising edge.
  task automatic tick();
    logic [DW-1:0] exp;
    @(negedge wclk);
    if (winc) begin
      if (sb.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
      else begin
        exp = sb.pop_front();
        chk("wdata", {24'd0, wdata}, {24'd0, exp});
      end
    end
    acc = s_valid && s_ready;
    if (acc) sb.push_back(s_data);
    if (s_valid && !s_ready) stall_model++;
    @(posedge wclk);
    #1;
  endtask

  initial begin
    logic [DW-1:0] seq;

    // Reset state
    #2 wrst_n = 1'b0;
    #1;
    chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
    chk("rst_winc", {31'd0, winc}, 32'd0);
    chk("rst_wlevel", {27'd0, wlevel}, 32'd0);
    chk("rst_afull", {31'd0, walmost_full}, 32'd0);
    chk("rst_stall", {16'd0, wstall_cnt}, 32'd0);
    @(posedge wclk); #1;
    chk("rst_hold_s_ready", {31'd0, s_ready}, 32'd0);
    wrst_n = 1'b1;
    @(posedge wclk); #1;
    chk("rel_s_ready", {31'd0, s_ready}, 32'd1);

    // Streaming with no backpressure
    for (int i = 0; i < 8; i++) begin
      s_valid = 1'b1;
      s_data  = DW'(8'h10 + i);
      chk("stream_winc", {31'd0, winc}, (i > 0) ? 32'd1 : 32'd0);
      chk("stream_s_ready", {31'd0, s_ready}, 32'd1);
      tick();
    end
    s_valid = 1'b0;
    tick();
    chk("stream_idle_winc", {31'd0, winc}, 32'd0);
    chk("stream_sb_empty", sb.size(), 32'd0);

    // Backpressure into HOLD2, then drain
    wfull = 1'b1; s_valid = 1'b1; s_data = 8'h20;
    tick();
    chk("bp_winc_blocked", {31'd0, winc}, 32'd0);
    s_data = 8'h21;
    tick();
    chk("bp_s_ready_low", {31'd0, s_ready}, 32'd0);
    s_data = 8'h22;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp_hold", {31'd0, s_ready}, 32'd0);
    end
    wfull = 1'b0;
    tick();
    chk("bp_ready_after_drain", {31'd0, s_ready}, 32'd1);
    tick();
    s_valid = 1'b0;
    tick();
    tick();
    chk("bp_sb_empty", sb.size(), 32'd0);
    chk("bp_stall_model", stall_model, 32'd5);
    chk("bp_wstall", {16'd0, wstall_cnt}, STATS ? 32'd5 : 32'd0);

    // Random valid with wfull toggling mid-burst
    seq = 8'h40;
    for (int i = 0; i < 60; i++) begin
      s_valid = 1'($urandom_range(0, 1));
      wfull   = ($urandom_range(0, 2) == 0);
      s_data  = seq;
      tick();
      if (acc) seq++;
    end
    s_valid = 1'b0; wfull = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("rand_sb_empty", sb.size(), 32'd0);
    chk("rand_wstall", {16'd0, wstall_cnt}, STATS ? 32'(stall_model) : 32'd0);

    // Level and almost-full
    wptr = gray(5'b10011); wq2_rptr = gray(5'b00011);
    @(posedge wclk); #1;
    chk("lvl_full_wrap", {27'd0, wlevel}, 32'd16);
    chk("afull_full", {31'd0, walmost_full}, 32'd1);
    wptr = gray(5'b00010); wq2_rptr = gray(5'b10110);
    @(posedge wclk); #1;
    chk("lvl_12", {27'd0, wlevel}, 32'd12);
    chk("afull_12", {31'd0, walmost_full}, 32'd1);
    wptr = gray(5'b00001);
    @(posedge wclk); #1;
    chk("lvl_11", {27'd0, wlevel}, 32'd11);
    chk("afull_11", {31'd0, walmost_full}, 32'd0);
    wptr = gray(5'b10110);
    @(posedge wclk); #1;
    chk("lvl_equal", {27'd0, wlevel}, 32'd0);
    wptr = gray(5'b00101); wq2_rptr = '0;
    @(posedge wclk); #1;
    chk("lvl_5", {27'd0, wlevel}, 32'd5);

    // Reset mid-HOLD2
    wfull = 1'b1; s_valid = 1'b1; s_data = 8'h70;
    tick();
    s_data = 8'h71;
    tick();
    chk("pre_rst_s_ready", {31'd0, s_ready}, 32'd0);
    wfull = 1'b0;
    #1;
    chk("pre_rst_winc", {31'd0, winc}, 32'd1);
    wrst_n = 1'b0;
    #1;
    chk("mid_rst_s_ready", {31'd0, s_ready}, 32'd0);
    chk("mid_rst_winc", {31'd0, winc}, 32'd0);
    chk("mid_rst_wlevel", {27'd0, wlevel}, 32'd0);
    chk("mid_rst_wstall", {16'd0, wstall_cnt}, 32'd0);
    sb.delete();
    stall_model = 0;
    s_valid = 1'b0; wptr = '0;
    @(posedge wclk); #1;
    wrst_n = 1'b1;
    @(posedge wclk); #1;
    chk("post_rst_s_ready", {31'd0, s_ready}, 32'd1);
    chk("post_rst_winc", {31'd0, winc}, 32'd0);

    // Clean word flows after reset
    s_valid = 1'b1; s_data = 8'h99;
    tick();
    s_valid = 1'b0;
    tick();
    chk("post_rst_sb_empty", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
